// File: rtl/pulse_sync_rx_multi.sv
// pulse_sync_rx_multi: per-channel toggle synchronizer with edge detect
// and a saturating pending-event counter behind a valid/ready handshake.
module pulse_sync_rx_multi #(
  parameter int   CH          = 4,
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 3,
  parameter logic TOGGLE_INIT = 1'b0
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [CH-1:0]       tog_async,
  output logic [CH-1:0]       evt_valid,
  input  logic [CH-1:0]       evt_ready,
  output logic [CH*CNT_W-1:0] pend_cnt,
  output logic [CH-1:0]       ovf,
  input  logic [CH-1:0]       ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   ovf_q;
    logic                   edge_d;
    logic                   acc;
    logic                   full;

    assign edge_d = sync_q[SYNC_STAGES-1] ^ hist_q;
    assign acc    = evt_ready[i] & (cnt_q != '0);
    assign full   = (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
      if (!rstn) begin
        sync_q <= {SYNC_STAGES{TOGGLE_INIT}};
        hist_q <= TOGGLE_INIT;
        cnt_q  <= '0;
        ovf_q  <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], tog_async[i]};
        hist_q <= sync_q[SYNC_STAGES-1];
        if (edge_d && !acc && !full)
          cnt_q <= cnt_q + CNT_ONE;
        else if (!edge_d && acc)
          cnt_q <= cnt_q - CNT_ONE;
        // a drop in the same cycle as a clear leaves the flag set
        if (edge_d && !acc && full)
          ovf_q <= 1'b1;
        else if (ovf_clr[i])
          ovf_q <= 1'b0;
      end
    end

    assign evt_valid[i]               = |cnt_q;
    assign pend_cnt[i*CNT_W +: CNT_W] = cnt_q;
    assign ovf[i]                     = ovf_q;
  end

endmodule

// File: tb/tb_pulse_sync_rx_multi.sv
// Bench for pulse_sync_rx_multi: default build plus a CH=1,
// SYNC_STAGES=3, CNT_W=1 build, checked against an event-queue model.
module tb_pulse_sync_rx_multi;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic [3:0]  tog_a, ready_a, clr_a, valid_a, ovf_a;
  logic [11:0] cnt_a;
  logic [0:0]  tog_b, ready_b, clr_b, valid_b, ovf_b, cnt_b;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  pulse_sync_rx_multi u_a (
    .clk(clk), .rstn(rstn), .tog_async(tog_a),
    .evt_valid(valid_a), .evt_ready(ready_a),
    .pend_cnt(cnt_a), .ovf(ovf_a), .ovf_clr(clr_a)
  );

  pulse_sync_rx_multi #(
    .CH(1), .SYNC_STAGES(3), .CNT_W(1)
  ) u_b (
    .clk(clk), .rstn(rstn), .tog_async(tog_b),
    .evt_valid(valid_b), .evt_ready(ready_b),
    .pend_cnt(cnt_b), .ovf(ovf_b), .ovf_clr(clr_b)
  );

  // model: sampled transitions become events SYNC_STAGES clocks later
  int   m_cnt [2][4];
  int   m_ovf [2][4];
  logic m_lvl [2][4];
  int   due_q [2][4][$];

  function automatic int nch(int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic int nsync(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic int cmax(int d);
    return (d == 0) ? 7 : 1;
  endfunction

  task automatic check(string tag, int ch,
                       logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s ch%0d got %0d exp %0d", tag, ch, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < nch(d); c++) begin
        logic t, r, k;
        bit   acc, ev, drop;
        t    = (d == 0) ? tog_a[c]   : tog_b[0];
        r    = (d == 0) ? ready_a[c] : ready_b[0];
        k    = (d == 0) ? clr_a[c]   : clr_b[0];
        acc  = (r === 1'b1) && (m_cnt[d][c] != 0);
        ev   = 1'b0;
        drop = 1'b0;
        if (due_q[d][c].size() > 0 && due_q[d][c][0] == cyc) begin
          ev = 1'b1;
          void'(due_q[d][c].pop_front());
        end
        if (!rstn) begin
          m_cnt[d][c] = 0;
          m_ovf[d][c] = 0;
          m_lvl[d][c] = 1'b0;
          due_q[d][c].delete();
        end else begin
          if (ev && !acc) begin
            if (m_cnt[d][c] < cmax(d)) m_cnt[d][c]++;
            else drop = 1'b1;
          end else if (!ev && acc) begin
            m_cnt[d][c]--;
          end
          if (drop) m_ovf[d][c] = 1;
          else if (k === 1'b1) m_ovf[d][c] = 0;
          if (t !== m_lvl[d][c]) begin
            due_q[d][c].push_back(cyc + nsync(d));
            m_lvl[d][c] = t;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < 4; c++) begin
      check("a_cnt", c, 32'(cnt_a[c*3 +: 3]), m_cnt[0][c]);
      check("a_vld", c, 32'(valid_a[c]), 32'(m_cnt[0][c] != 0));
      check("a_ovf", c, 32'(ovf_a[c]), m_ovf[0][c]);
    end
    check("b_cnt", 0, 32'(cnt_b), m_cnt[1][0]);
    check("b_vld", 0, 32'(valid_b), 32'(m_cnt[1][0] != 0));
    check("b_ovf", 0, 32'(ovf_b), m_ovf[1][0]);
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all();
  endtask

  task automatic ticks(int n);
    repeat (n) tick();
  endtask

  task automatic measure(string tag, int d, int exp_lat);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (((d == 0) ? !valid_a[0] : !valid_b[0]) && n < 12);
    check(tag, 0, n, exp_lat);
  endtask

  int hold [5];

  initial begin
    rstn = 1'b0;
    tog_a = '0; ready_a = '0; clr_a = '0;
    tog_b = '0; ready_b = '0; clr_b = '0;
    ticks(2);
    check("rst_cnt_a", 0, 32'(cnt_a), 0);
    check("rst_ovf_a", 0, 32'(ovf_a), 0);
    check("rst_vld_b", 0, 32'(valid_b), 0);
    rstn = 1'b1;
    ticks(2);

    // basic latency on ch0
    tog_a[0] = 1'b1;
    measure("lat_a", 0, 3);
    check("lat_a_cnt", 0, 32'(cnt_a[2:0]), 1);
    check("lat_a_oth", 0, 32'(cnt_a[11:3]), 0);
    ready_a[0] = 1'b1;
    tick();
    check("acc_a_cnt", 0, 32'(cnt_a[2:0]), 0);
    ready_a[0] = 1'b0;

    // queuing and saturation on ch1
    for (int k = 0; k < 9; k++) begin
      tog_a[1] = ~tog_a[1];
      ticks(4);
    end
    check("sat_cnt", 1, 32'(cnt_a[5:3]), 7);
    check("sat_ovf", 1, 32'(ovf_a[1]), 1);
    ready_a[1] = 1'b1;
    ticks(7);
    check("drain_vld", 1, 32'(valid_a[1]), 0);
    check("drain_ovf", 1, 32'(ovf_a[1]), 1);
    ready_a[1] = 1'b0;

    // simultaneous event and accept on ch2
    tog_a[2] = ~tog_a[2]; ticks(2);
    tog_a[2] = ~tog_a[2]; ticks(4);
    check("sim_pre", 2, 32'(cnt_a[8:6]), 2);
    tog_a[2] = ~tog_a[2]; ticks(2);
    ready_a[2] = 1'b1;
    tick();
    check("sim_hold", 2, 32'(cnt_a[8:6]), 2);
    tick();
    check("sim_dec", 2, 32'(cnt_a[8:6]), 1);
    ready_a[2] = 1'b0;

    // overflow set/clear race on ch3
    for (int k = 0; k < 7; k++) begin
      tog_a[3] = ~tog_a[3];
      ticks(2);
    end
    ticks(3);
    check("race_pre", 3, 32'(cnt_a[11:9]), 7);
    check("race_ovf0", 3, 32'(ovf_a[3]), 0);
    tog_a[3] = ~tog_a[3]; ticks(2);
    clr_a[3] = 1'b1;
    tick();
    check("race_set", 3, 32'(ovf_a[3]), 1);
    clr_a[3] = 1'b0;
    tick();
    clr_a[3] = 1'b1;
    tick();
    check("race_clr", 3, 32'(ovf_a[3]), 0);
    clr_a[3] = 1'b0;

    // load 3/5/0/7 with ovf3 set, then reset mid-operation
    ready_a[2] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k < 3) tog_a[0] = ~tog_a[0];
      tog_a[1] = ~tog_a[1];
      if (k == 0) tog_a[3] = ~tog_a[3];
      ticks(2);
    end
    ticks(3);
    ready_a[2] = 1'b0;
    check("mid_cnt", 0, 32'(cnt_a), 32'({3'd7, 3'd0, 3'd5, 3'd3}));
    check("mid_ovf", 3, 32'(ovf_a[3]), 1);
    tog_a = 4'b1010;
    rstn = 1'b0;
    tick();
    check("rst_mid_cnt", 0, 32'(cnt_a), 0);
    check("rst_mid_ovf", 0, 32'(ovf_a), 0);
    rstn = 1'b1;
    ticks(2);
    check("post_rst_early", 0, 32'(valid_a), 0);
    tick();
    check("post_rst_vld", 0, 32'(valid_a), 32'(4'b1010));
    ticks(3);
    check("post_rst_cnt", 0, 32'(cnt_a), 32'({3'd1, 3'd0, 3'd1, 3'd0}));

    // swept build: latency 4, saturates at 1
    tog_b = 1'b1;
    measure("lat_b", 1, 4);
    ready_b = 1'b1;
    tick();
    check("acc_b", 0, 32'(cnt_b), 0);
    ready_b = 1'b0;
    tog_b = 1'b0; ticks(3);
    tog_b = 1'b1; ticks(5);
    check("sat_b_cnt", 0, 32'(cnt_b), 1);
    check("sat_b_ovf", 0, 32'(ovf_b), 1);
    clr_b = 1'b1;
    tick();
    clr_b = 1'b0;
    check("clr_b", 0, 32'(ovf_b), 0);

    // randomized traffic on both builds
    for (int i = 0; i < 5; i++) hold[i] = 0;
    for (int n = 0; n < 600; n++) begin
      for (int c = 0; c < 5; c++) begin
        hold[c]++;
        if (hold[c] >= 2 && $urandom_range(0, 2) == 0) begin
          if (c < 4) tog_a[c] = ~tog_a[c];
          else tog_b = ~tog_b;
          hold[c] = 0;
        end
      end
      ready_a = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0;
      ready_b = 1'($urandom_range(0, 3) == 0);
      clr_a   = ($urandom_range(0, 15) == 0) ? 4'($urandom) : 4'b0;
      clr_b   = 1'($urandom_range(0, 15) == 0);
      rstn    = ($urandom_range(0, 199) != 0);
      tick();
    end
    rstn = 1'b1;
    ready_a = '0; ready_b = '0; clr_a = '0; clr_b = '0;
    ticks(6);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pulse_sync_rx_multi.md
Name: pulse_sync_rx_multi

Overview:
Receive side of a toggle-encoded pulse synchronizer, generalised to CH independent channels. Each channel takes an asynchronous toggle from a foreign clock domain and passes it through a SYNC_STAGES-deep synchronizer, then edge-detects it. Every toggle transition becomes one event, and events are queued in a per-channel saturating pending counter. Events are released through a per-channel valid/ready handshake, so a stalled consumer loses nothing until the counter saturates, which raises a sticky overflow flag.

Parameters:
CH, 4, number of independent channels (>=1)
SYNC_STAGES, 2, flops in each synchronizer chain (>=2)
CNT_W, 3, pending-counter width per channel; max pending = 2^CNT_W-1
TOGGLE_INIT, 1'b0, reset value of every sync stage and of the edge-detect history

Ports:
clk  input  1  single clock for the whole block
rstn  input  1  synchronous, active-low reset
tog_async  input  CH  per-channel toggle from foreign domain; one transition = one event
evt_valid  output  CH  channel has >=1 pending event
evt_ready  input  CH  consumer accepts one event on a cycle with evt_valid&evt_ready
pend_cnt  output  CH*CNT_W  pending count; channel i at [i*CNT_W +: CNT_W]
ovf  output  CH  sticky: an event was dropped at saturation
ovf_clr  input  CH  clears ovf for that channel

Behaviour:
- Reset: one clock, clk only, synchronous and active-low. While rstn=0 at a posedge:
  - all sync stages and edge history load TOGGLE_INIT;
  - pend_cnt=0, evt_valid=0, ovf=0.
  - No spurious event may be produced on reset release while tog_async==TOGGLE_INIT.
- Synchronizer: stage0 samples tog_async[i]; stage k takes stage k-1; hist takes stage SYNC_STAGES-1.
- Edge: edge[i] = stage[SYNC_STAGES-1] ^ hist. Rising and falling transitions both count as one event.
- Latency: if tog_async changes before posedge P1, then:
  - edge is asserted during the cycle after posedge P(SYNC_STAGES);
  - pend_cnt increments and evt_valid rises after posedge P(SYNC_STAGES+1);
  - with the default, that is 3 clocks.
- Source rule: the source must hold each toggle level for at least 2 clk periods. Faster toggling loses events undetected; this is out of contract.
- Counter update per channel, each posedge (acc = evt_valid & evt_ready):
  - edge & !acc & cnt<max: cnt+1
  - edge & !acc & cnt==max: cnt holds, ovf<=1 (event dropped)
  - !edge & acc: cnt-1
  - edge & acc: cnt unchanged (simultaneous in/out)
  - neither: hold
- evt_valid = (pend_cnt!=0). It is a function of registered state only, with no combinational path from evt_ready or tog_async.
- evt_ready with evt_valid=0 is ignored; the count never underflows.
- ovf: set as above, cleared by ovf_clr. If set and clear occur in the same cycle, set wins.
- Channels are fully independent; there is no arbitration between channels.
- Reset mid-operation discards all pending events and overflow state.

Test Plan:
- Basic latency: CH=4, defaults; reset, then toggle tog_async[0] 0->1 once -> evt_valid[0] rises exactly 3 clks after the first sampling edge. pend_cnt[0]=1, then 0 one cycle after evt_ready[0]=1. Other channels remain 0.
- Queuing and saturation: hold evt_ready[1]=0 and toggle tog_async[1] 9 times, each level held 4 clks -> pend_cnt[1] climbs to 7 and holds at 7. ovf[1]=1 after the 8th event. Then evt_ready[1]=1 drains 7 events over 7 cycles, evt_valid[1] falls, ovf[1] stays 1.
- Simultaneous event and accept: pend_cnt[2]=2, and an edge coincides with an accepted handshake -> pend_cnt[2] stays 2. Next cycle with ready only -> 1.
- Overflow clear race: pend_cnt[3]=7, and a new edge coincides with ovf_clr[3]=1 while ovf[3]=0 -> ovf[3]=1. A later ovf_clr[3] with no edge -> ovf[3]=0.
- Reset mid-operation: pend_cnt=3/5/0/7 and ovf[3]=1; assert rstn=0 for 1 clk while tog_async=4'b1010 -> all counts 0, ovf=0. After release, each channel whose input differs from TOGGLE_INIT (here ch1 and ch3) produces exactly one event 3 clks later; ch0 and ch2 produce none.
- Parameter sweep: SYNC_STAGES=3, CNT_W=1, CH=1; run the first two scenarios -> latency is 4 clks and saturation occurs at count 1.
